// File: rtl/noc_mem_responder_if.sv
// ---------------------------------------------------------------------------
// axi4_stream_if
//
// Purpose : AXI4-Stream beat carrier between NoC routers and local endpoints.
//           One bundle per direction; the producer uses the Master modport,
//           the consumer uses the Slave modport.
//
// Signals :
//   tvalid / tready      - beat handshake
//   tdata  [DATA_W]      - payload
//   tstrb  [DATA_W/8]    - byte qualifiers for tdata
//   tkeep  [DATA_W/8]    - byte presence
//   tlast                - packet boundary marker
//   tid    [ID_W]        - transaction tag
//   tdest  [DEST_W]      - destination (memory address for this NoC)
//   tuser  [USER_W]      - routing sideband {err, wr, src_yx, dst_yx}
// ---------------------------------------------------------------------------
interface axi4_stream_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 16,
    parameter int ID_W   = 4,
    parameter int USER_W = 10
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [ID_W-1:0]       tid;
    logic [DEST_W-1:0]     tdest;
    logic [USER_W-1:0]     tuser;

    modport Master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport Slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/noc_mem_responder.sv
// ---------------------------------------------------------------------------
// noc_mem_responder
//
// Purpose : Memory-side endpoint of the XY-routed NoC. Accepts one request
//           beat at a time from the local router output, performs the read or
//           write on a single-port memory, and returns exactly one response
//           beat (same tid) addressed back to the requester. Requests whose
//           destination is not this node are answered with err=1 and never
//           touch memory.
//
// Ports   :
//   clk, rst_n     - clock, synchronous active-low reset
//   noc_req_i      - AXI4-Stream slave, request beats from the router
//   noc_rsp_o      - AXI4-Stream master, response beats into the router
//   mem_req_o      - memory request (held until mem_gnt_i)
//   mem_we_o       - 1 = write, 0 = read
//   mem_addr_o     - address, taken from request tdest
//   mem_wdata_o    - write data, taken from request tdata
//   mem_be_o       - byte enables, taken from request tstrb
//   mem_gnt_i      - memory accepted the request this cycle
//   mem_rvalid_i   - read data valid
//   mem_rdata_i    - read data
//
// State table:
//   IDLE  | ready for a request beat, tready=1
//   MREQ  | request presented to memory, waiting for grant
//   MWAIT | read granted, waiting for read data
//   RSP   | response beat presented, waiting for tready
// ---------------------------------------------------------------------------
module noc_mem_responder #(
    parameter int DX_W   = 2,
    parameter int DY_W   = 2,
    parameter int CUR_X  = 0,
    parameter int CUR_Y  = 0,
    // Must match the tdata / tdest widths of the attached interfaces.
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    axi4_stream_if.Slave          noc_req_i,
    axi4_stream_if.Master         noc_rsp_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int ID_W    = $bits(noc_req_i.tid);
    localparam int TUSER_W = $bits(noc_req_i.tuser);
    localparam int C       = DX_W + DY_W;

    // This node's coordinates in tuser order {y, x}.
    localparam logic [C-1:0] HERE = {DY_W'(CUR_Y), DX_W'(CUR_X)};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MREQ  = 2'd1,
        ST_MWAIT = 2'd2,
        ST_RSP   = 2'd3
    } state_e;

    state_e               state_q, state_d;

    // Captured request beat. data_q holds the write data until a read
    // completes, then the read data; the two never coexist.
    logic [DATA_W-1:0]    data_q,  data_d;
    logic [STRB_W-1:0]    strb_q,  strb_d;
    logic                 last_q,  last_d;
    logic [ID_W-1:0]      id_q,    id_d;
    logic [ADDR_W-1:0]    dest_q,  dest_d;
    logic [C-1:0]         src_q,   src_d;
    logic                 wr_q,    wr_d;
    logic                 err_q,   err_d;

    logic                 accept;
    logic                 route_ok;
    logic [C-1:0]         req_dst;
    logic [C-1:0]         req_src;
    logic                 req_wr;
    logic [TUSER_W-1:0]   rsp_user;

    assign req_dst  = noc_req_i.tuser[C-1:0];
    assign req_src  = noc_req_i.tuser[2*C-1:C];
    assign req_wr   = noc_req_i.tuser[2*C];
    assign route_ok = (req_dst == HERE);

    // tready depends only on state (and reset), so a handshake in IDLE is
    // simply tvalid.
    assign accept   = (state_q == ST_IDLE) && noc_req_i.tvalid;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (noc_req_i.tvalid) begin
                    state_d = route_ok ? ST_MREQ : ST_RSP;
                end
            end
            ST_MREQ: begin
                if (mem_gnt_i) begin
                    state_d = wr_q ? ST_RSP : ST_MWAIT;
                end
            end
            ST_MWAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (noc_rsp_o.tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Captured-beat registers
    // -----------------------------------------------------------------------
    always_comb begin
        data_d = data_q;
        strb_d = strb_q;
        last_d = last_q;
        id_d   = id_q;
        dest_d = dest_q;
        src_d  = src_q;
        wr_d   = wr_q;
        err_d  = err_q;

        if (accept) begin
            data_d = noc_req_i.tdata;
            strb_d = noc_req_i.tstrb;
            last_d = noc_req_i.tlast;
            id_d   = noc_req_i.tid;
            dest_d = noc_req_i.tdest;
            src_d  = req_src;
            wr_d   = req_wr;
            err_d  = !route_ok;
        end

        // Read data is only taken while a read is actually outstanding, so a
        // stray rvalid after a reset or during any other state is harmless.
        if ((state_q == ST_MWAIT) && mem_rvalid_i) begin
            data_d = mem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            strb_q <= '0;
            last_q <= 1'b0;
            id_q   <= '0;
            dest_q <= '0;
            src_q  <= '0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            strb_q <= strb_d;
            last_q <= last_d;
            id_q   <= id_d;
            dest_q <= dest_d;
            src_q  <= src_d;
            wr_q   <= wr_d;
            err_q  <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        rsp_user           = '0;
        rsp_user[C-1:0]    = src_q;
        rsp_user[2*C-1:C]  = HERE;
        rsp_user[2*C]      = wr_q;
        rsp_user[2*C+1]    = err_q;
    end

    always_comb begin
        // Gated with rst_n so tready is low for the whole reset, including
        // the cycles after the state register has already returned to IDLE.
        noc_req_i.tready = rst_n && (state_q == ST_IDLE);

        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (state_q == ST_MREQ) begin
            mem_req_o   = 1'b1;
            mem_we_o    = wr_q;
            mem_addr_o  = dest_q;
            mem_wdata_o = data_q;
            mem_be_o    = strb_q;
        end

        noc_rsp_o.tvalid = 1'b0;
        noc_rsp_o.tdata  = '0;
        noc_rsp_o.tstrb  = '0;
        noc_rsp_o.tkeep  = '0;
        noc_rsp_o.tlast  = 1'b0;
        noc_rsp_o.tid    = '0;
        noc_rsp_o.tdest  = '0;
        noc_rsp_o.tuser  = '0;
        if (state_q == ST_RSP) begin
            noc_rsp_o.tvalid = 1'b1;
            // Only a successful read returns data; data_q still holds the
            // request payload for writes and misrouted beats.
            noc_rsp_o.tdata  = (wr_q || err_q) ? '0 : data_q;
            noc_rsp_o.tstrb  = '1;
            noc_rsp_o.tkeep  = '1;
            noc_rsp_o.tlast  = last_q;
            noc_rsp_o.tid    = id_q;
            noc_rsp_o.tdest  = dest_q;
            noc_rsp_o.tuser  = rsp_user;
        end
    end

endmodule

// File: tb/tb_noc_mem_responder.sv
module tb_noc_mem_responder;

    localparam logic [1:0] CX = 2'd1;
    localparam logic [1:0] CY = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    axi4_stream_if #(.DATA_W(32), .DEST_W(16), .ID_W(4), .USER_W(10)) req_if ();
    axi4_stream_if #(.DATA_W(32), .DEST_W(16), .ID_W(4), .USER_W(10)) rsp_if ();

    noc_mem_responder #(
        .DX_W(2), .DY_W(2), .CUR_X(1), .CUR_Y(2), .DATA_W(32), .ADDR_W(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .noc_req_i    (req_if),
        .noc_rsp_o    (rsp_if),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Expected outputs for the current cycle, written by the stimulus.
    logic        chk_en = 1'b0;
    logic        e_rst, e_ready, e_mreq, e_we, e_rvalid, e_rlast;
    logic [15:0] e_addr, e_rdest;
    logic [31:0] e_wdata, e_rdata;
    logic [3:0]  e_be, e_rid;
    logic [9:0]  e_ruser;

    // Transaction-level model: memory contents.
    logic [31:0] mem_m [logic [15:0]];

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        if (!mem_m.exists(a)) mem_m[a] = $urandom;
        return mem_m[a];
    endfunction

    // Observations used for the literal pins.
    int          cyc = 0;
    int          req_cyc = 0;
    int          rsp_lat = -1;
    logic        rsp_seen = 1'b1;
    int          rsp_cnt = 0;
    int          gnt_cnt = 0;
    logic [31:0] got_data;
    logic [9:0]  got_user;
    logic [3:0]  got_id;
    logic [15:0] got_maddr;
    logic [3:0]  got_mbe;
    logic        got_mwe;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_tready", req_if.tready, e_ready);
            chk("mem_req", mem_req_o, e_mreq);
            if (e_mreq || e_rst) begin
                chk("mem_we", mem_we_o, e_we);
                chk("mem_addr", mem_addr_o, e_addr);
                chk("mem_wdata", mem_wdata_o, e_wdata);
                chk("mem_be", mem_be_o, e_be);
            end
            chk("rsp_tvalid", rsp_if.tvalid, e_rvalid);
            if (e_rvalid || e_rst) begin
                chk("rsp_tdata", rsp_if.tdata, e_rdata);
                chk("rsp_tstrb", rsp_if.tstrb, e_rst ? 4'h0 : 4'hF);
                chk("rsp_tkeep", rsp_if.tkeep, e_rst ? 4'h0 : 4'hF);
                chk("rsp_tlast", rsp_if.tlast, e_rlast);
                chk("rsp_tid", rsp_if.tid, e_rid);
                chk("rsp_tdest", rsp_if.tdest, e_rdest);
                chk("rsp_tuser", rsp_if.tuser, e_ruser);
            end
        end
        if (rst_n === 1'b1 && req_if.tvalid && req_if.tready) begin
            req_cyc  = cyc;
            rsp_seen = 1'b0;
        end
        if (rsp_if.tvalid === 1'b1 && !rsp_seen) begin
            rsp_seen = 1'b1;
            rsp_lat  = cyc - req_cyc;
        end
        if (rsp_if.tvalid === 1'b1 && rsp_if.tready) begin
            rsp_cnt++;
            got_data = rsp_if.tdata;
            got_user = rsp_if.tuser;
            got_id   = rsp_if.tid;
        end
        if (mem_req_o === 1'b1 && mem_gnt_i) begin
            gnt_cnt++;
            got_maddr = mem_addr_o;
            got_mbe   = mem_be_o;
            got_mwe   = mem_we_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        e_rst = 0; e_ready = 1; e_mreq = 0; e_rvalid = 0;
    endtask

    task automatic exp_reset();
        e_rst = 1; e_ready = 0; e_mreq = 0; e_rvalid = 0;
        e_we = 0; e_addr = 0; e_wdata = 0; e_be = 0;
        e_rdata = 0; e_rlast = 0; e_rid = 0; e_rdest = 0; e_ruser = 0;
    endtask

    task automatic drive_req(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] id, input logic last,
                             input logic [1:0] dx, input logic [1:0] dy,
                             input logic [1:0] sx, input logic [1:0] sy);
        req_if.tvalid = 1;
        req_if.tdata  = data;
        req_if.tstrb  = strb;
        req_if.tkeep  = 4'hF;
        req_if.tlast  = last;
        req_if.tid    = id;
        req_if.tdest  = addr;
        req_if.tuser  = {1'($urandom), wr, sy, sx, dy, dx};
    endtask

    task automatic scramble_req();
        req_if.tvalid = 0;
        req_if.tdata  = $urandom;
        req_if.tstrb  = 4'($urandom);
        req_if.tlast  = 1'($urandom);
        req_if.tid    = 4'($urandom);
        req_if.tdest  = 16'($urandom);
        req_if.tuser  = 10'($urandom);
    endtask

    // One full transaction: request beat, memory waits, response waits.
    task automatic txn(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [3:0] id, input logic last,
                       input logic [1:0] dx, input logic [1:0] dy,
                       input logic [1:0] sx, input logic [1:0] sy,
                       input int gw, input int rw, input int tw);
        logic        routed;
        logic [31:0] rd;
        logic [31:0] tmp;
        routed = (dx == CX) && (dy == CY);
        rd = 0;
        drive_req(wr, addr, data, strb, id, last, dx, dy, sx, sy);
        mem_rvalid_i = 1'($urandom);
        mem_rdata_i  = $urandom;
        exp_idle();
        step();
        scramble_req();
        if (routed) begin
            for (int k = 0; k <= gw; k++) begin
                mem_gnt_i    = (k == gw);
                mem_rvalid_i = 1'($urandom);
                mem_rdata_i  = $urandom;
                e_rst = 0; e_ready = 0; e_mreq = 1; e_rvalid = 0;
                e_we = wr; e_addr = addr; e_wdata = data; e_be = strb;
                if (k == gw && wr) begin
                    tmp = mem_rd(addr);
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) tmp[8*b +: 8] = data[8*b +: 8];
                    mem_m[addr] = tmp;
                end
                step();
            end
            mem_gnt_i = 0;
            if (!wr) begin
                rd = mem_rd(addr);
                for (int k = 0; k <= rw; k++) begin
                    mem_rvalid_i = (k == rw);
                    mem_rdata_i  = (k == rw) ? rd : $urandom;
                    e_rst = 0; e_ready = 0; e_mreq = 0; e_rvalid = 0;
                    step();
                end
            end
        end
        for (int k = 0; k <= tw; k++) begin
            rsp_if.tready = (k == tw);
            mem_rvalid_i  = 1'($urandom);
            mem_rdata_i   = $urandom;
            e_rst = 0; e_ready = 0; e_mreq = 0; e_rvalid = 1;
            e_rdata = (routed && !wr) ? rd : 32'h0;
            e_rlast = last; e_rid = id; e_rdest = addr;
            e_ruser = {!routed, wr, CY, CX, sy, sx};
            step();
        end
        rsp_if.tready = 0;
        mem_rvalid_i  = 0;
        exp_idle();
    endtask

    initial begin
        int cnt0;
        int g0;
        rst_n = 0;
        req_if.tvalid = 0; req_if.tdata = 0; req_if.tstrb = 0; req_if.tkeep = 0;
        req_if.tlast = 0; req_if.tid = 0; req_if.tdest = 0; req_if.tuser = 0;
        rsp_if.tready = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        exp_reset();
        step();
        chk_en = 1;
        exp_reset();
        step();
        step();
        rst_n = 1;
        exp_idle();

        // Directed write at node (1,2)
        txn(1, 16'h0040, 32'hDEADBEEF, 4'hF, 4'd5, 1, CX, CY, 2'd0, 2'd0, 0, 0, 0);
        chk("wr_lat", rsp_lat, 2);
        chk("wr_rsp_user", got_user, 10'h190);
        chk("wr_rsp_data", got_data, 32'h0);
        chk("wr_rsp_id", got_id, 4'd5);
        chk("wr_mem_addr", got_maddr, 16'h0040);
        chk("wr_mem_be", got_mbe, 4'hF);
        chk("wr_mem_we", got_mwe, 1'b1);

        // Directed read
        txn(0, 16'h0040, 32'h0, 4'hF, 4'd9, 1, CX, CY, 2'd0, 2'd0, 0, 0, 0);
        chk("rd_lat", rsp_lat, 3);
        chk("rd_rsp_data", got_data, 32'hDEADBEEF);
        chk("rd_rsp_id", got_id, 4'd9);
        chk("rd_rsp_user", got_user, 10'h090);

        // Backpressure on grant and on response
        txn(1, 16'h0080, 32'h12345678, 4'h5, 4'd1, 0, CX, CY, 2'd3, 2'd1, 4, 0, 3);
        chk("bp_lat", rsp_lat, 6);
        txn(0, 16'h0080, 32'h0, 4'hF, 4'd2, 0, CX, CY, 2'd2, 2'd3, 2, 3, 2);

        // Zero-strobe write still reaches memory and changes nothing
        g0 = gnt_cnt;
        txn(1, 16'h0040, 32'hFFFFFFFF, 4'h0, 4'd4, 1, CX, CY, 2'd0, 2'd0, 0, 0, 0);
        chk("be0_issued", gnt_cnt, g0 + 1);
        chk("be0_mem_be", got_mbe, 4'h0);
        txn(0, 16'h0040, 32'h0, 4'hF, 4'd6, 1, CX, CY, 2'd0, 2'd0, 1, 1, 0);
        chk("be0_readback", got_data, 32'hDEADBEEF);

        // Misrouted request
        g0 = gnt_cnt;
        txn(0, 16'h0010, 32'hCAFEF00D, 4'hF, 4'd3, 1, 2'd3, 2'd3, 2'd0, 2'd0, 0, 0, 0);
        chk("mis_lat", rsp_lat, 1);
        chk("mis_no_mem", gnt_cnt, g0);
        chk("mis_rsp_user", got_user, 10'h290);
        chk("mis_rsp_data", got_data, 32'h0);

        // Reset while a read waits for data
        cnt0 = rsp_cnt;
        drive_req(0, 16'h0040, 32'h0, 4'hF, 4'd7, 1, CX, CY, 2'd1, 2'd1);
        exp_idle();
        step();
        scramble_req();
        mem_gnt_i = 1;
        e_rst = 0; e_ready = 0; e_mreq = 1; e_rvalid = 0;
        e_we = 0; e_addr = 16'h0040; e_wdata = 32'h0; e_be = 4'hF;
        step();
        mem_gnt_i = 0;
        rst_n = 0;
        e_rst = 0; e_ready = 0; e_mreq = 0; e_rvalid = 0;
        step();
        exp_reset();
        step();
        rst_n = 1;
        mem_rvalid_i = 1;
        mem_rdata_i  = 32'h55AA55AA;
        exp_idle();
        step();
        mem_rvalid_i = 0;
        step();
        step();
        chk("rst_no_rsp", rsp_cnt, cnt0);
        txn(0, 16'h0040, 32'h0, 4'hF, 4'd8, 0, CX, CY, 2'd0, 2'd1, 0, 0, 0);
        chk("post_rst_lat", rsp_lat, 3);
        chk("post_rst_data", got_data, 32'hDEADBEEF);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            logic [1:0] dx, dy;
            if ($urandom_range(0, 3) != 0) begin
                dx = CX; dy = CY;
            end else begin
                dx = 2'($urandom); dy = 2'($urandom);
            end
            txn(1'($urandom), 16'($urandom_range(0, 7) * 4), $urandom, 4'($urandom),
                4'($urandom), 1'($urandom), dx, dy, 2'($urandom), 2'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        chk("rsp_total", rsp_cnt, 68);

        step();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

endmodule
